// File: rtl/vga_pkg.sv
// Shared VGA constants: visible raster size, black level and sprite-mover FSM encodings.
package vga_pkg;
  localparam logic [9:0] H_VIS       = 10'd640;
  localparam logic [9:0] V_VIS       = 10'd480;
  localparam logic [7:0] COLOR_BLACK = 8'h00;

  localparam logic [1:0] S_DRAW   = 2'd0;
  localparam logic [1:0] S_UPDATE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
endpackage

// File: rtl/sprite_renderer_if.sv
// Timing-generator inputs, movement buttons and DAC-side outputs of the sprite renderer.
interface sprite_renderer_if;
  logic       strobe;
  logic       hsync_in;
  logic       vsync_in;
  logic       active;
  logic [9:0] xpos;
  logic [9:0] ypos;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic [7:0] rgb;
  logic       hsync_out;
  logic       vsync_out;
  logic       frame_tick;

  modport master (
    output strobe, hsync_in, vsync_in, active, xpos, ypos,
           btn_up, btn_down, btn_left, btn_right,
    input  rgb, hsync_out, vsync_out, frame_tick
  );

  modport slave (
    input  strobe, hsync_in, vsync_in, active, xpos, ypos,
           btn_up, btn_down, btn_left, btn_right,
    output rgb, hsync_out, vsync_out, frame_tick
  );
endinterface

// File: rtl/sprite_pos_ctrl.sv
// Sticky movement requests and a vsync-driven FSM that moves the sprite once per frame,
// clamping it to the visible area.
module sprite_pos_ctrl
  import vga_pkg::*;
#(
  parameter logic [9:0] SPR_W  = 10'd32,
  parameter logic [9:0] SPR_H  = 10'd32,
  parameter logic [9:0] STEP   = 10'd4,
  parameter logic [9:0] INIT_X = 10'd304,
  parameter logic [9:0] INIT_Y = 10'd224
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe_i,
  input  logic       vsync_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       btn_left_i,
  input  logic       btn_right_i,
  output logic [9:0] spr_x_o,
  output logic [9:0] spr_y_o,
  output logic       frame_tick_o
);

  logic [1:0] state_q, state_d;
  logic [3:0] req_q, req_d;  // {up, down, left, right}
  logic [9:0] spr_x_q, spr_x_d, spr_y_q, spr_y_d;
  logic       vs_prev_q, tick_q;
  logic [3:0] btn;
  logic       upd;

  assign btn = {btn_up_i, btn_down_i, btn_left_i, btn_right_i};
  assign upd = strobe_i && (state_q == S_UPDATE);

  function automatic logic [9:0] move(input logic [9:0] pos, input logic inc,
                                      input logic dec, input logic [9:0] lim);
    logic signed [10:0] p;
    p = $signed({1'b0, pos});
    if (inc && !dec)      p = p + $signed({1'b0, STEP});
    else if (dec && !inc) p = p - $signed({1'b0, STEP});
    if (p < 11'sd0)                return 10'd0;
    if (p > $signed({1'b0, lim}))  return lim;
    return p[9:0];
  endfunction

  always_comb begin
    state_d = state_q;
    req_d   = req_q | btn;
    spr_x_d = spr_x_q;
    spr_y_d = spr_y_q;
    if (strobe_i) begin
      case (state_q)
        S_DRAW:   if (vs_prev_q && !vsync_i) state_d = S_UPDATE;
        S_UPDATE: begin
          state_d = S_WAIT;
          // presses landing on the update clock survive into the next frame
          req_d   = btn;
          spr_x_d = move(spr_x_q, req_q[0], req_q[1], H_VIS - SPR_W);
          spr_y_d = move(spr_y_q, req_q[2], req_q[3], V_VIS - SPR_H);
        end
        S_WAIT:   if (vsync_i) state_d = S_DRAW;
        default:  state_d = S_DRAW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_DRAW;
      req_q     <= 4'b0;
      spr_x_q   <= INIT_X;
      spr_y_q   <= INIT_Y;
      vs_prev_q <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      spr_x_q <= spr_x_d;
      spr_y_q <= spr_y_d;
      tick_q  <= upd;
      if (strobe_i) vs_prev_q <= vsync_i;
    end
  end

  assign spr_x_o      = spr_x_q;
  assign spr_y_o      = spr_y_q;
  assign frame_tick_o = tick_q;
endmodule

// File: rtl/sprite_renderer.sv
// Two-stage pixel colour pipeline (hit test, then colour select) with matching sync delay.
module sprite_renderer
  import vga_pkg::*;
#(
  parameter logic [9:0] SPR_W        = 10'd32,
  parameter logic [9:0] SPR_H        = 10'd32,
  parameter logic [9:0] STEP         = 10'd4,
  parameter logic [9:0] INIT_X       = 10'd304,
  parameter logic [9:0] INIT_Y       = 10'd224,
  parameter logic [7:0] SPR_COLOR    = 8'hE0,
  parameter logic [7:0] BORDER_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR     = 8'h02
) (
  input logic              clk,
  input logic              rst,
  sprite_renderer_if.slave bus
);

  logic [9:0]  spr_x, spr_y;
  logic [10:0] x_end, y_end;
  logic        spr_hit, bord_hit;
  logic        act1_q, spr1_q, bord1_q, hs1_q, vs1_q;
  logic [7:0]  rgb_q, rgb_d;
  logic        hs2_q, vs2_q;

  sprite_pos_ctrl #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .STEP(STEP), .INIT_X(INIT_X), .INIT_Y(INIT_Y)
  ) u_pos (
    .clk         (clk),
    .rst         (rst),
    .strobe_i    (bus.strobe),
    .vsync_i     (bus.vsync_in),
    .btn_up_i    (bus.btn_up),
    .btn_down_i  (bus.btn_down),
    .btn_left_i  (bus.btn_left),
    .btn_right_i (bus.btn_right),
    .spr_x_o     (spr_x),
    .spr_y_o     (spr_y),
    .frame_tick_o(bus.frame_tick)
  );

  // 11-bit ends so the right/bottom edge never wraps
  assign x_end    = {1'b0, spr_x} + {1'b0, SPR_W};
  assign y_end    = {1'b0, spr_y} + {1'b0, SPR_H};
  assign spr_hit  = (bus.xpos >= spr_x) && ({1'b0, bus.xpos} < x_end) &&
                    (bus.ypos >= spr_y) && ({1'b0, bus.ypos} < y_end);
  assign bord_hit = (bus.xpos == 10'd0) || (bus.xpos == H_VIS - 10'd1) ||
                    (bus.ypos == 10'd0) || (bus.ypos == V_VIS - 10'd1);

  always_comb begin
    rgb_d = COLOR_BLACK;
    if (act1_q) begin
      if (spr1_q)       rgb_d = SPR_COLOR;
      else if (bord1_q) rgb_d = BORDER_COLOR;
      else              rgb_d = BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act1_q  <= 1'b0;
      spr1_q  <= 1'b0;
      bord1_q <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      rgb_q   <= COLOR_BLACK;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
    end else if (bus.strobe) begin
      act1_q  <= bus.active;
      spr1_q  <= spr_hit;
      bord1_q <= bord_hit;
      hs1_q   <= bus.hsync_in;
      vs1_q   <= bus.vsync_in;
      rgb_q   <= rgb_d;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.hsync_out = hs2_q;
  assign bus.vsync_out = vs2_q;
endmodule

// File: tb/tb_sprite_renderer.sv
// Directed + randomized bench: pixel colours and sync delay against a coordinate-level
// reference, sprite motion against a per-frame position model.
module tb_sprite_renderer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   tick_cnt = 0;
  int   mx = 304;
  int   my = 224;
  bit   ru, rd, rl, rr;
  logic [9:0] expq[$];
  logic [9:0] last_exp;

  localparam logic [9:0] RESET_ENTRY = {8'h00, 1'b1, 1'b1};

  always #5 clk = ~clk;

  sprite_renderer_if bus();
  sprite_renderer dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ref_color(int x, int y, bit act);
    if (!act) return 8'h00;
    if (x >= mx && x < mx + 32 && y >= my && y < my + 32) return 8'hE0;
    if (x == 0 || x == 639 || y == 0 || y == 479) return 8'hFF;
    return 8'h02;
  endfunction

  function automatic int cl(int v, int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(int x, int y, bit act, bit hs, bit vs);
    bus.xpos = 10'(x); bus.ypos = 10'(y); bus.active = act;
    bus.hsync_in = hs; bus.vsync_in = vs; bus.strobe = 1'b1;
    expq.push_back({ref_color(x, y, act), hs, vs});
    @(posedge clk); #1;
    if (bus.frame_tick === 1'b1) tick_cnt++;
    last_exp = expq.pop_front();
    chk("rgb", bus.rgb, last_exp[9:2]);
    chk("hsync_out", bus.hsync_out, last_exp[1]);
    chk("vsync_out", bus.vsync_out, last_exp[0]);
  endtask

  task automatic idle(int n);
    bus.strobe = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (bus.frame_tick === 1'b1) tick_cnt++;
      chk("hold_rgb", bus.rgb, last_exp[9:2]);
      chk("hold_hsync", bus.hsync_out, last_exp[1]);
    end
  endtask

  task automatic hold(bit u, bit d, bit l, bit r);
    bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r;
    ru |= u; rd |= d; rl |= l; rr |= r;
  endtask

  // one-clock press while strobe is low
  task automatic pulse(bit u, bit d, bit l, bit r);
    hold(u, d, l, r);
    idle(1);
    hold(0, 0, 0, 0);
  endtask

  task automatic model_update();
    int nx = mx;
    int ny = my;
    if (rr && !rl) nx += 4; else if (rl && !rr) nx -= 4;
    if (rd && !ru) ny += 4; else if (ru && !rd) ny -= 4;
    mx = cl(nx, 608); my = cl(ny, 448);
    ru = bus.btn_up; rd = bus.btn_down; rl = bus.btn_left; rr = bus.btn_right;
  endtask

  task automatic model_reset();
    mx = 304; my = 224; ru = 0; rd = 0; rl = 0; rr = 0;
    expq.delete(); expq.push_back(RESET_ENTRY); last_exp = RESET_ENTRY;
  endtask

  task automatic do_reset();
    hold(0, 0, 0, 0);
    bus.strobe = 1'b0; bus.vsync_in = 1'b1; bus.hsync_in = 1'b1; bus.active = 1'b0;
    rst = 1'b0; #2;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic frame(string tag);
    int rx = int'($urandom_range(0, 639));
    int ry = int'($urandom_range(0, 479));
    step(cl(mx - 1, 639), my, 1, 1, 1);
    step(mx, my, 1, 0, 1);
    step(mx + 31, my + 31, 1, 1, 1);
    step(cl(mx + 32, 639), my, 1, 1, 1);
    step(0, 0, 1, 1, 1);
    step(639, 479, 1, 1, 1);
    step(rx, ry, 1, bit'($urandom_range(0, 1)), 1);
    step(rx, ry, 0, 1, 1);
    tick_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      if (i == 1) model_update();
      chk({tag, "_tick"}, bus.frame_tick, (i == 1));
    end
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    chk({tag, "_tick_count"}, tick_cnt, 1);
    chk({tag, "_spr_x"}, dut.u_pos.spr_x_q, mx);
    chk({tag, "_spr_y"}, dut.u_pos.spr_y_q, my);
  endtask

  initial begin
    bus.strobe = 0; bus.hsync_in = 1; bus.vsync_in = 1; bus.active = 0;
    bus.xpos = 0; bus.ypos = 0;
    bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
    model_reset();
    #2 rst = 1'b0;
    #10;
    chk("reset_rgb", bus.rgb, 8'h00);
    chk("reset_hsync", bus.hsync_out, 1'b1);
    chk("reset_vsync", bus.vsync_out, 1'b1);
    chk("reset_tick", bus.frame_tick, 1'b0);
    chk("reset_spr_x", dut.u_pos.spr_x_q, 304);
    chk("reset_spr_y", dut.u_pos.spr_y_q, 224);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // 1: static frame, key pixels
    step(0, 0, 1, 1, 1);
    step(100, 100, 1, 0, 1);
    step(304, 224, 1, 1, 1);
    step(335, 255, 1, 1, 1);
    chk("t1_sprite_corner", bus.rgb, 8'hE0);
    step(336, 224, 1, 1, 1);
    chk("t1_sprite_right_edge", bus.rgb, 8'hE0);
    step(500, 300, 0, 1, 1);
    chk("t1_right_of_sprite", bus.rgb, 8'h02);
    step(10, 10, 1, 1, 1);
    chk("t1_blank", bus.rgb, 8'h00);
    idle(3);
    frame("t1");

    // 2: one-clock right press mid-frame; current frame keeps old position
    step(200, 200, 1, 1, 1);
    pulse(0, 0, 0, 1);
    step(mx, my, 1, 1, 1);
    step(mx + 32, my, 1, 1, 1);
    frame("t2");
    chk("t2_x308", dut.u_pos.spr_x_q, 308);

    // 5: up+down cancel, right still moves
    pulse(1, 1, 0, 1);
    frame("t5");
    chk("t5_y_unchanged", dut.u_pos.spr_y_q, 224);

    // 6: walk to x=200, then reset while in S_WAIT
    hold(0, 0, 1, 0);
    repeat (27) frame("t6_walk");
    hold(0, 0, 0, 0);
    frame("t6_walk");
    chk("t6_x200", dut.u_pos.spr_x_q, 200);
    step(50, 50, 1, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0);
      if (i == 1) model_update();
    end
    rst = 1'b0;
    #1;
    chk("t6_rst_spr_x", dut.u_pos.spr_x_q, 304);
    chk("t6_rst_rgb", bus.rgb, 8'h00);
    chk("t6_rst_hsync", bus.hsync_out, 1'b1);
    chk("t6_rst_vsync", bus.vsync_out, 1'b1);
    chk("t6_rst_tick", bus.frame_tick, 1'b0);
    bus.strobe = 1'b0; bus.vsync_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    tick_cnt = 0;
    repeat (4) step(0, 0, 0, 1, 1);
    chk("t6_no_tick_before_edge", tick_cnt, 0);
    frame("t6");

    // 3: hold left for 100 frames, saturate at 0
    do_reset();
    hold(0, 0, 1, 0);
    repeat (100) frame("t3");
    chk("t3_x_sat", dut.u_pos.spr_x_q, 0);

    // 4: hold down for 100 frames, sprite beats border on the last line
    do_reset();
    hold(0, 1, 0, 0);
    repeat (100) frame("t4");
    chk("t4_y_sat", dut.u_pos.spr_y_q, 448);
    step(304, 479, 1, 1, 1);
    step(304, 100, 1, 1, 1);
    chk("t4_sprite_over_border", bus.rgb, 8'hE0);
    hold(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
